flex_counter: RTL and testbench

Parameterized synchronous up-counter with a run-time programmable rollover value, a synchronous clear and a count enable. It provides a registered count and a registered rollover flag. It is a generic building block for bit/byte counters, timers and shift-length tracking inside protocol and slave-interface logic.

---
 rtl/flex_counter.sv | 59 +++++
 tb/tb_flex_counter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/flex_counter.sv
// Parameterized up-counter with run-time rollover value, synchronous clear and
// count enable; count and rollover flag are both registered.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] LP_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] LP_ONE  = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_flag;
  logic [NUM_CNT_BITS-1:0] w_nextCount;
  logic                    w_nextFlag;
  logic                    w_atRollover;
  logic                    w_rollZero;

  assign w_atRollover = (r_count == rollover_val);
  assign w_rollZero   = (rollover_val == LP_ZERO);

  // A zero rollover value parks the count at 0; otherwise the terminal count wraps to one.
  always_comb begin
    w_nextCount = r_count;
    if (clear) begin
      w_nextCount = LP_ZERO;
    end else if (count_enable) begin
      if (w_rollZero) begin
        w_nextCount = LP_ZERO;
      end else if (w_atRollover) begin
        w_nextCount = LP_ONE;
      end else begin
        w_nextCount = r_count + LP_ONE;
      end
    end
  end

  assign w_nextFlag = (w_nextCount == rollover_val);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_count <= LP_ZERO;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_flag  <= w_nextFlag;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

endmodule

// File: tb/tb_flex_counter.sv
// Directed testbench for flex_counter: linear sequence of steps with
// hand-computed expected count and flag values.
module tb_flex_counter;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       count_enable;
  logic [3:0] rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag;

  int errors = 0;
  int checks = 0;

  flex_counter #(.NUM_CNT_BITS(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic clr, input logic en,
                               input logic [3:0] rv);
    n_rst        = rst;
    clear        = clr;
    count_enable = en;
    rollover_val = rv;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tickClock(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expCount,
                             input logic expFlag);
    checks++;
    assert (count_out === expCount) else begin
      errors++;
      $error("[TB] FAIL %s count: got %0d expected %0d", tag, count_out, expCount);
    end
    checks++;
    assert (rollover_flag === expFlag) else begin
      errors++;
      $error("[TB] FAIL %s flag: got %0b expected %0b", tag, rollover_flag, expFlag);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    #1;

    // Reset dominates clear/enable; after release with R=0 the flag rises.
    tickClock(2);
    checkOutput("reset", 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    tickClock(2);
    checkOutput("post_reset_r0", 4'd0, 1'b1);

    // Count to 7 with R=7, freeze, then wrap to one.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd7);
    tickClock(1);
    checkOutput("r7_first", 4'd1, 1'b0);
    tickClock(6);
    checkOutput("r7_at_term", 4'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd7);
    tickClock(1);
    checkOutput("r7_frozen", 4'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd7);
    tickClock(1);
    checkOutput("r7_wrap", 4'd1, 1'b0);

    // Continuous counting with R=15 from zero.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd15);
    tickClock(1);
    checkOutput("clear_to_zero", 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd15);
    tickClock(14);
    checkOutput("r15_at14", 4'd14, 1'b0);
    tickClock(1);
    checkOutput("r15_at15", 4'd15, 1'b1);
    tickClock(1);
    checkOutput("r15_wrap", 4'd1, 1'b0);

    // Discontinuous counting: 8 enabled, 8 idle, 8 enabled.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd15);
    tickClock(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd15);
    tickClock(8);
    checkOutput("disc_first8", 4'd8, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd15);
    tickClock(8);
    checkOutput("disc_idle", 4'd8, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd15);
    tickClock(7);
    checkOutput("disc_at15", 4'd15, 1'b1);
    tickClock(1);
    checkOutput("disc_wrap", 4'd1, 1'b0);

    // Clear beats enable; release resumes counting from zero.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd15);
    tickClock(5);
    checkOutput("clear_vs_en", 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd15);
    tickClock(1);
    checkOutput("clear_release", 4'd1, 1'b0);

    // Reset mid-count at 5 with enable high.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd15);
    tickClock(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd15);
    tickClock(5);
    checkOutput("pre_reset5", 4'd5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd15);
    tickClock(1);
    checkOutput("reset_mid", 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd15);
    tickClock(1);
    checkOutput("after_reset_mid", 4'd1, 1'b0);

    // Dropping R to 0 while counting parks the count at 0 with flag high.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    tickClock(1);
    checkOutput("r0_park", 4'd0, 1'b1);
    tickClock(1);
    checkOutput("r0_hold", 4'd0, 1'b1);

    // Lowering R below the count lets the count run past it.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd3);
    tickClock(3);
    checkOutput("r3_at_term", 4'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2);
    tickClock(1);
    checkOutput("r_below_count", 4'd4, 1'b0);

    // Natural 4-bit wrap 15 -> 0 when R is below the count.
    tickClock(11);
    checkOutput("natural_at15", 4'd15, 1'b0);
    tickClock(1);
    checkOutput("natural_wrap0", 4'd0, 1'b0);
    tickClock(2);
    checkOutput("natural_to_r", 4'd2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
